// File: rtl/conv2d_engine.sv
// Multi-channel 2-D convolution, one tap per cycle, N+2 cycles per output; a stalled output freezes the engine.
// Define CONV_RELU_EN to clamp negative results to zero on out_data.
module conv2d_engine #(
  parameter int K_H    = 3,
  parameter int K_W    = 3,
  parameter int IN_H   = 16,
  parameter int IN_W   = 15,
  parameter int IN_CH  = 1,
  parameter int OUT_CH = 10,
  parameter int STRIDE = 1,
  parameter int ACC_W  = 24,
  // derived address widths; leave at their defaults
  parameter int AA = (IN_CH * IN_H * IN_W > 1) ? $clog2(IN_CH * IN_H * IN_W) : 1,
  parameter int WA = (OUT_CH * IN_CH * K_H * K_W > 1) ? $clog2(OUT_CH * IN_CH * K_H * K_W) : 1,
  parameter int OA = (OUT_CH * ((IN_H - K_H) / STRIDE + 1) * ((IN_W - K_W) / STRIDE + 1) > 1) ?
                     $clog2(OUT_CH * ((IN_H - K_H) / STRIDE + 1) * ((IN_W - K_W) / STRIDE + 1)) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic [AA-1:0]           act_addr,
  input  logic [7:0]              act_data,
  output logic [WA-1:0]           w_addr,
  input  logic [7:0]              w_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] out_data,
  output logic [OA-1:0]           out_addr,
  output logic                    out_last
);

  localparam int OUT_H = (IN_H - K_H) / STRIDE + 1;
  localparam int OUT_W = (IN_W - K_W) / STRIDE + 1;
  localparam int CW    = 16;

  localparam logic [CW-1:0] ONE    = CW'(1);
  localparam logic [CW-1:0] KW_M1  = CW'(K_W - 1);
  localparam logic [CW-1:0] KH_M1  = CW'(K_H - 1);
  localparam logic [CW-1:0] IC_M1  = CW'(IN_CH - 1);
  localparam logic [CW-1:0] OW_M1  = CW'(OUT_W - 1);
  localparam logic [CW-1:0] OH_M1  = CW'(OUT_H - 1);
  localparam logic [CW-1:0] OC_M1  = CW'(OUT_CH - 1);

  typedef enum logic [1:0] {IDLE, MAC, DRAIN, EMIT} state_t;

  state_t state, state_nxt;

  logic [CW-1:0] kx, ky, ic;
  logic [CW-1:0] ox, oy, oc;
  logic [OA-1:0] out_idx;

  logic signed [ACC_W-1:0] acc;
  logic                    rd_vld;

  logic last_tap, last_pix;
  logic load, tap_step, pix_step, fin;

  logic signed [16:0] act_s, w_s, prod;

  assign last_tap = (kx == KW_M1) && (ky == KH_M1) && (ic == IC_M1);
  assign last_pix = (ox == OW_M1) && (oy == OH_M1) && (oc == OC_M1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    out_valid = 1'b0;
    out_last  = 1'b0;
    load      = 1'b0;
    tap_step  = 1'b0;
    pix_step  = 1'b0;
    fin       = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          load      = 1'b1;
          state_nxt = MAC;
        end
      end
      MAC: begin
        tap_step = 1'b1;
        if (last_tap) state_nxt = DRAIN;
      end
      DRAIN: state_nxt = EMIT;
      EMIT: begin
        out_valid = 1'b1;
        out_last  = last_pix;
        if (out_ready) begin
          if (last_pix) begin
            fin       = 1'b1;
            state_nxt = IDLE;
          end else begin
            pix_step  = 1'b1;
            state_nxt = MAC;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Tap counters wrap to zero on the final tap, so they are ready for the next pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kx <= '0;
      ky <= '0;
      ic <= '0;
    end else if (load) begin
      kx <= '0;
      ky <= '0;
      ic <= '0;
    end else if (tap_step) begin
      if (kx == KW_M1) begin
        kx <= '0;
        if (ky == KH_M1) begin
          ky <= '0;
          ic <= (ic == IC_M1) ? '0 : ic + ONE;
        end else begin
          ky <= ky + ONE;
        end
      end else begin
        kx <= kx + ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ox      <= '0;
      oy      <= '0;
      oc      <= '0;
      out_idx <= '0;
    end else if (load) begin
      ox      <= '0;
      oy      <= '0;
      oc      <= '0;
      out_idx <= '0;
    end else if (pix_step) begin
      out_idx <= out_idx + OA'(1);
      if (ox == OW_M1) begin
        ox <= '0;
        if (oy == OH_M1) begin
          oy <= '0;
          oc <= oc + ONE;
        end else begin
          oy <= oy + ONE;
        end
      end else begin
        ox <= ox + ONE;
      end
    end
  end

  assign act_addr = AA'(ic) * AA'(IN_H * IN_W)
                  + (AA'(oy) * AA'(STRIDE) + AA'(ky)) * AA'(IN_W)
                  + AA'(ox) * AA'(STRIDE) + AA'(kx);

  assign w_addr = ((WA'(oc) * WA'(IN_CH) + WA'(ic)) * WA'(K_H) + WA'(ky)) * WA'(K_W) + WA'(kx);

  // Activation is unsigned, so it gets a zero sign bit before the signed multiply.
  assign act_s = {9'b0, act_data};
  assign w_s   = {{9{w_data[7]}}, w_data};
  assign prod  = act_s * w_s;

  // rd_vld marks the cycle in which read data for the previous MAC-cycle tap is present.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_vld <= 1'b0;
    else        rd_vld <= (state == MAC);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                acc <= '0;
    else if (load || pix_step) acc <= '0;
    else if (rd_vld)           acc <= acc + ACC_W'(prod);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) done <= 1'b0;
    else        done <= fin;
  end

  assign out_addr = out_idx;

  always_comb begin
    out_data = '0;
    if (state == EMIT) begin
`ifdef CONV_RELU_EN
      out_data = acc[ACC_W-1] ? '0 : acc;
`else
      out_data = acc;
`endif
    end
  end

endmodule
